down_counter: RTL and testbench
===============================

# down_counter

Loadable down-counting timer that complements the free-running up counter in the DVI test path: it is loaded with a cycle count, counts down on enabled clocks, and flags terminal count. It times fixed-length intervals such as blanking windows, settle delays and test-pattern dwell periods, where the up counter only measures elapsed time. Optional periodic auto-reload turns it into a programmable rate generator.

## Interface
- `WIDTH`, 20: counter and load-value width in bits.
- `clk` input 1: sole clock, rising edge.
- `sclr_n` input 1: synchronous active-low reset.
- `load` input 1: load request, sampled each cycle.
- `load_val` input WIDTH: value captured when `load`=1.
- `en` input 1: count enable.
- `periodic` input 1: auto-reload mode select, sampled each cycle. Honoured only with `DOWN_COUNTER_RELOAD_EN`.
- `q` output WIDTH: current count, registered.
- `busy` output 1: high while the counter is in the RUN state.
- `tc` output 1: terminal-count pulse, one cycle wide, registered.
- `done` output 1: sticky one-shot completion flag.

## Operation
- States are IDLE and RUN.
- Reset (`sclr_n`=0 at a clk edge), any state:
  - `q`=0, state IDLE, `busy`=0, `tc`=0, `done`=0.
  - Reload register cleared.
  - Reset overrides `load` and `en`.
- `load`=1, any state, highest priority after reset:
  - `q`←`load_val` and reload register←`load_val`.
  - `done`←0 and `tc`←0.
  - If `load_val`≠0, go to RUN. If `load_val`=0, go to IDLE and never assert `tc`.
- RUN, `en`=1, `q`>1: `q`←`q`−1.
- RUN, `en`=1, `q`=1 (terminal step):
  - `tc`←1 for exactly one cycle.
  - If in periodic mode: `q`←reload register and stay in RUN.
  - Otherwise: `q`←0, go to IDLE, `done`←1.
- RUN, `en`=0: hold `q`. `tc`←0.
- IDLE: `q` holds and `en` is ignored. The counter never wraps below 0.
- `load` on the terminal-step cycle: the load wins, `tc` stays 0 and `done` stays 0.
- Arithmetic is unsigned, WIDTH bits. Decrement never underflows because RUN implies `q`≥1.
- Effective period is `load_val` enabled cycles. With `load_val`=2^WIDTH−1 the period is 2^WIDTH−1 enabled cycles.

## Timing
- All outputs are registered. There are no combinational input-to-output paths.
- `load` at edge k: `q`=`load_val` and `busy`=1 are visible after edge k.
- Continuous `en` after a load of N (one-shot):
  - `q` reaches 0 at edge k+N.
  - `tc`=1 and `done`=1 after edge k+N.
  - `busy`=0 after edge k+N.
- `tc` deasserts on the following edge, whatever the inputs, unless another terminal step occurs.
- Periodic mode: `tc` pulses every N enabled cycles, with no dead cycle at the reload.
- A change of `periodic` takes effect at the next terminal step.
- Reset mid-count: outputs reach their reset values at the same edge. No `tc` is emitted.

## Configuration
- `DOWN_COUNTER_RELOAD_EN` defined:
  - The reload register is implemented.
  - `periodic`=1 selects auto-reload as described above.
- `DOWN_COUNTER_RELOAD_EN` undefined:
  - The reload register is omitted.
  - `periodic` is ignored; the port stays present but is unused.
  - Every terminal step behaves as one-shot: `q`←0, go to IDLE, `done`←1.

## Test plan
- Reset, then load 5 with `en`=1 held:
  - `q` sequence 5,4,3,2,1,0.
  - `tc`=1 for one cycle exactly when `q`=0.
  - `done`=1; `busy`=0 from that edge.
- Load 4, `en` toggling 1,0,1,0,…: `q` decrements only on enabled edges. `tc` arrives after 4 enabled edges, 7 edges after the load.
- Load 0: `busy`=0, `q`=0, `tc` and `done` stay 0 for 10 cycles.
- `DOWN_COUNTER_RELOAD_EN` defined, `periodic`=1, load 3, `en`=1:
  - `q` sequence 3,2,1,3,2,1,…
  - `tc` on cycles 3, 6, 9; `busy` stays 1; `done` stays 0.
  - Same stimulus with the macro undefined: a single `tc`, then IDLE with `q`=0.
- Load 8, then reload 2 exactly on the terminal-step cycle: no `tc` that cycle, and `q`=2. Separately, drive `sclr_n`=0 with `q`=3: all outputs 0 next edge and no `tc`.
- `WIDTH`=20, load 0xFFFFF: first decrement gives 0xFFFFE. After 2^20−1 enabled cycles `tc` fires once and `q`=0.

Source files
------------

// File: rtl/down_counter.sv
// down_counter: loadable down-counting interval timer with terminal-count pulse.
//
// A load captures a cycle count. The counter then decrements on enabled clocks
// while in RUN and flags the terminal step with a one-cycle tc pulse. In
// one-shot operation it then returns to IDLE with q=0 and raises a sticky done.
//
// Build option: define DOWN_COUNTER_RELOAD_EN to add the reload register.
// With it, periodic=1 reloads q from the last loaded value at each terminal
// step, so the counter becomes a programmable rate generator. Without it,
// periodic is ignored and every terminal step behaves as one-shot.
//
// Parameters:
//   WIDTH     counter and load-value width in bits
// Ports:
//   clk       sole clock, rising edge
//   sclr_n    synchronous active-low reset
//   load      load request; captures load_val (highest priority after reset)
//   load_val  count to load
//   en        count enable (used only in RUN)
//   periodic  auto-reload select (used only with DOWN_COUNTER_RELOAD_EN)
//   q         current count, registered
//   busy      high while in RUN
//   tc        terminal-count pulse, one cycle, registered
//   done      sticky one-shot completion flag, registered
module down_counter #(
  parameter int unsigned WIDTH = 20
) (
  input  logic             clk,
  input  logic             sclr_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             periodic,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             tc_nxt;
  logic             done_nxt;
  logic             reload_now;

`ifdef DOWN_COUNTER_RELOAD_EN
  logic [WIDTH-1:0] reload;
  logic [WIDTH-1:0] reload_nxt;

  assign reload_now = periodic;
`else
  logic unused_periodic;

  assign unused_periodic = periodic;
  assign reload_now      = 1'b0;
`endif

  // State and output registers
  always_ff @(posedge clk) begin
    if (!sclr_n) begin
      state <= IDLE;
      q     <= '0;
      tc    <= 1'b0;
      done  <= 1'b0;
`ifdef DOWN_COUNTER_RELOAD_EN
      reload <= '0;
`endif
    end else begin
      state <= state_nxt;
      q     <= q_nxt;
      tc    <= tc_nxt;
      done  <= done_nxt;
`ifdef DOWN_COUNTER_RELOAD_EN
      reload <= reload_nxt;
`endif
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt = state;
    q_nxt     = q;
    tc_nxt    = 1'b0;
    done_nxt  = done;
`ifdef DOWN_COUNTER_RELOAD_EN
    reload_nxt = reload;
`endif

    if (load) begin
      // A load pre-empts any terminal step in the same cycle.
      q_nxt     = load_val;
      done_nxt  = 1'b0;
      state_nxt = (load_val != '0) ? RUN : IDLE;
`ifdef DOWN_COUNTER_RELOAD_EN
      reload_nxt = load_val;
`endif
    end else if (state == RUN && en) begin
      if (q == WIDTH'(1)) begin
        tc_nxt = 1'b1;
        if (reload_now) begin
`ifdef DOWN_COUNTER_RELOAD_EN
          // Reload holds a non-zero value whenever RUN was entered via load.
          q_nxt = reload;
`endif
        end else begin
          q_nxt     = '0;
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end else begin
        // RUN implies q >= 1, so this never underflows.
        q_nxt = q - WIDTH'(1);
      end
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_down_counter.sv
// Directed self-checking bench for down_counter (20-bit main instance plus a
// 4-bit instance for the full-range period check).
module tb_down_counter;

  localparam int unsigned W  = 20;
  localparam int unsigned WS = 4;

  logic          clk;
  logic          sclr_n;
  logic          load;
  logic [W-1:0]  load_val;
  logic          en;
  logic          periodic;
  logic [W-1:0]  q;
  logic          busy;
  logic          tc;
  logic          done;

  logic          s_sclr_n;
  logic          s_load;
  logic [WS-1:0] s_load_val;
  logic          s_en;
  logic [WS-1:0] s_q;
  logic          s_busy;
  logic          s_tc;
  logic          s_done;

  int total = 0;
  int bad   = 0;

  down_counter #(.WIDTH(W)) dut (
    .clk      (clk),
    .sclr_n   (sclr_n),
    .load     (load),
    .load_val (load_val),
    .en       (en),
    .periodic (periodic),
    .q        (q),
    .busy     (busy),
    .tc       (tc),
    .done     (done)
  );

  down_counter #(.WIDTH(WS)) dut_s (
    .clk      (clk),
    .sclr_n   (s_sclr_n),
    .load     (s_load),
    .load_val (s_load_val),
    .en       (s_en),
    .periodic (1'b0),
    .q        (s_q),
    .busy     (s_busy),
    .tc       (s_tc),
    .done     (s_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int eq, input bit eb,
                         input bit et, input bit ed);
    chk({tag, ".q"},    32'(q),    32'(eq));
    chk({tag, ".busy"}, 32'(busy), 32'(eb));
    chk({tag, ".tc"},   32'(tc),   32'(et));
    chk({tag, ".done"}, 32'(done), 32'(ed));
  endtask

  initial begin
    sclr_n = 1'b0; load = 1'b0; load_val = '0; en = 1'b0; periodic = 1'b0;
    s_sclr_n = 1'b0; s_load = 1'b0; s_load_val = '0; s_en = 1'b0;

    // Reset state
    step();
    chk_all("reset", 0, 1'b0, 1'b0, 1'b0);

    // One-shot load 5 with en held
    sclr_n = 1'b1; load = 1'b1; load_val = W'(5); en = 1'b1;
    step();
    chk_all("ld5", 5, 1'b1, 1'b0, 1'b0);
    load = 1'b0;
    for (int i = 4; i >= 0; i--) begin
      step();
      chk_all($sformatf("ld5_q%0d", i), i, i != 0, i == 0, i == 0);
    end
    step();
    chk_all("ld5_after", 0, 1'b0, 1'b0, 1'b1);

    // Load 4 with en toggling: tc on the 7th edge after the load
    load = 1'b1; load_val = W'(4); en = 1'b0;
    step();
    chk_all("ld4", 4, 1'b1, 1'b0, 1'b0);
    load = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      en = (e % 2 == 1);
      step();
      chk_all($sformatf("tog_e%0d", e), 4 - (e + 1) / 2, e != 7, e == 7, e == 7);
    end

    // Load 0: stays idle, no tc, done cleared by the load
    load = 1'b1; load_val = '0; en = 1'b1;
    step();
    chk_all("ld0", 0, 1'b0, 1'b0, 1'b0);
    load = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      step();
      chk_all($sformatf("ld0_c%0d", c), 0, 1'b0, 1'b0, 1'b0);
    end

    // Periodic request, load 3
    periodic = 1'b1; load = 1'b1; load_val = W'(3); en = 1'b1;
    step();
    chk_all("per_ld", 3, 1'b1, 1'b0, 1'b0);
    load = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      step();
`ifdef DOWN_COUNTER_RELOAD_EN
      chk_all($sformatf("per_c%0d", c), (c % 3 == 0) ? 3 : 3 - (c % 3),
              1'b1, c % 3 == 0, 1'b0);
`else
      chk_all($sformatf("per_c%0d", c), (c >= 3) ? 0 : 3 - c,
              c < 3, c == 3, c >= 3);
`endif
    end
    periodic = 1'b0;

    // Load 8, then reload 2 on the terminal-step cycle
    load = 1'b1; load_val = W'(8); en = 1'b1;
    step();
    load = 1'b0;
    for (int c = 1; c <= 7; c++) step();
    chk_all("ld8_at1", 1, 1'b1, 1'b0, 1'b0);
    load = 1'b1; load_val = W'(2);
    step();
    chk_all("ld8_reload2", 2, 1'b1, 1'b0, 1'b0);
    load = 1'b0;
    step();
    chk_all("rl2_q1", 1, 1'b1, 1'b0, 1'b0);
    step();
    chk_all("rl2_q0", 0, 1'b0, 1'b1, 1'b1);

    // Reset mid-count at q=3
    load = 1'b1; load_val = W'(5);
    step();
    load = 1'b0;
    step();
    step();
    chk_all("pre_rst", 3, 1'b1, 1'b0, 1'b0);
    sclr_n = 1'b0;
    step();
    chk_all("mid_rst", 0, 1'b0, 1'b0, 1'b0);
    step();
    chk_all("mid_rst2", 0, 1'b0, 1'b0, 1'b0);
    sclr_n = 1'b1;

    // Full-scale load value
    load = 1'b1; load_val = W'(20'hFFFFF);
    step();
    chk_all("max_ld", 32'hFFFFF, 1'b1, 1'b0, 1'b0);
    load = 1'b0;
    step();
    chk_all("max_dec", 32'hFFFFE, 1'b1, 1'b0, 1'b0);

    // Full-range period on the 4-bit instance: 15 enabled cycles, single tc
    chk("s_reset.q", 32'(s_q), 32'd0);
    s_sclr_n = 1'b1; s_load = 1'b1; s_load_val = 4'hF; s_en = 1'b1;
    step();
    chk("s_ld.q", 32'(s_q), 32'd15);
    s_load = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      step();
      chk($sformatf("s_c%0d.q", c),  32'(s_q),  32'(15 - c));
      chk($sformatf("s_c%0d.tc", c), 32'(s_tc), 32'(c == 15));
    end
    chk("s_end.done", 32'(s_done), 32'd1);
    chk("s_end.busy", 32'(s_busy), 32'd0);
    step();
    chk("s_post.tc", 32'(s_tc), 32'd0);
    chk("s_post.q",  32'(s_q),  32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
